// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch SRAM-like responder: turns each accepted fetch into a single-beat
// AXI read and returns the R beat to IF as a one-cycle data_ok pulse.
module inst_sram_axi_rd_bridge #(
  parameter logic [3:0]  ARID            = 4'h0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  axi_rid_out,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  ar_state_t        ar_state;
  logic [CNT_W-1:0] out_cnt;
  logic [1:0]       size_q;
  logic             accept;
  logic             r_hs;

  // Writes are never issued and single-beat reads need neither rresp nor rlast.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, inst_sram_wr, rresp, rlast};

  assign inst_sram_addr_ok = resetn & (ar_state == AR_IDLE)
                           & (out_cnt < CNT_W'(MAX_OUTSTANDING));
  assign accept            = inst_sram_req & inst_sram_addr_ok;
  assign rready            = (out_cnt != '0);
  assign r_hs              = rvalid & rready;

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // AR channel FSM: one address phase at a time, held until the slave takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      size_q   <= 2'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept) begin
            ar_state <= AR_SEND;
            arvalid  <= 1'b1;
            araddr   <= inst_sram_addr;
            size_q   <= inst_sram_size;
          end
        end
        AR_SEND: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: begin
          ar_state <= AR_IDLE;
          arvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Requests accepted but not yet answered on R.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_cnt <= '0;
    end else begin
      case ({accept, r_hs})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // R beat returned to IF one cycle after the handshake; data and ID hold between pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
      axi_rid_out       <= 4'd0;
    end else begin
      inst_sram_data_ok <= r_hs;
      if (r_hs) begin
        inst_sram_rdata <= rdata;
        axi_rid_out     <= rid;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Bench for inst_sram_axi_rd_bridge: directed scenarios plus a randomized run
// scored against an in-order fetch queue.
module tb_inst_sram_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  axi_rid_out;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference view: fetches in flight, pending address phase, pending data pulse.
  int          m_cnt = 0;
  bit          m_ar_pend = 1'b0;
  logic [31:0] m_araddr = '0;
  logic [1:0]  m_arsize = '0;
  bit          m_dok = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_rid = '0;

  logic [31:0] ar_q[$];
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  inst_sram_axi_rd_bridge #(.ARID(4'h0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .axi_rid_out(axi_rid_out),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  function automatic bit exp_addr_ok();
    return resetn && !m_ar_pend && (m_cnt < 2);
  endfunction

  task automatic drive(input logic req, input logic [31:0] addr, input logic ary,
                       input logic rv, input logic [31:0] d, input logic [3:0] id);
    inst_sram_req  = req;
    inst_sram_addr = addr;
    arready        = ary;
    rvalid         = rv;
    rdata          = d;
    rid            = id;
  endtask

  // Advance one clock and update the reference view from the inputs of that cycle.
  task automatic tick();
    bit          rst, acc, rhs, arhs;
    logic [31:0] a, d;
    logic [1:0]  s;
    logic [3:0]  id;
    rst  = !resetn;
    acc  = inst_sram_req && exp_addr_ok();
    rhs  = rvalid && (m_cnt != 0);
    arhs = m_ar_pend && arready;
    a = inst_sram_addr; s = inst_sram_size; d = rdata; id = rid;
    @(posedge clk); #1;
    if (rst) begin
      m_cnt = 0; m_ar_pend = 0; m_araddr = '0; m_arsize = '0;
      m_dok = 0; m_rdata = '0; m_rid = '0;
    end else begin
      m_cnt = m_cnt + int'(acc) - int'(rhs);
      if (arhs) m_ar_pend = 0;
      if (acc) begin m_ar_pend = 1; m_araddr = a; m_arsize = s; end
      m_dok = rhs;
      if (rhs) begin m_rdata = d; m_rid = id; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_sram_size = 2'd2;
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF);
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got addr_ok/arvalid/rready/data_ok=%b need 0000",
                        {inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok});
    end
    n_cmp++;
    if ({inst_sram_rdata, axi_rid_out, araddr, arsize} !== 71'd0) begin
      n_err++; $display("FAIL reset_data: got rdata=%h rid=%h araddr=%h arsize=%h need all 0",
                        inst_sram_rdata, axi_rid_out, araddr, arsize);
    end
    n_cmp++;
    if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'h0, 8'h0, 2'b01, 2'b0, 4'h0, 3'h0}) begin
      n_err++; $display("FAIL ar_consts: got arid=%h arlen=%h arburst=%b need 0/0/01",
                        arid, arlen, arburst);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h1C00_0000, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if (inst_sram_addr_ok !== 1'b1) begin
      n_err++; $display("FAIL single_addr_ok: got %b need 1", inst_sram_addr_ok);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({arvalid, araddr, arsize} !== {1'b1, 32'h1C00_0000, 3'b010}) begin
      n_err++; $display("FAIL single_ar: got arvalid=%b araddr=%h arsize=%b need 1 1c000000 010",
                        arvalid, araddr, arsize);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 32'h0280_0000, 4'h0);
    @(negedge clk);
    n_cmp++;
    if ({arvalid, rready, inst_sram_data_ok} !== 3'b010) begin
      n_err++; $display("FAIL single_r: got arvalid/rready/data_ok=%b need 010",
                        {arvalid, rready, inst_sram_data_ok});
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata, axi_rid_out} !== {1'b1, 32'h0280_0000, 4'h0}) begin
      n_err++; $display("FAIL single_data: got data_ok=%b rdata=%h rid=%h need 1 02800000 0",
                        inst_sram_data_ok, inst_sram_rdata, axi_rid_out);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b0, 32'h0280_0000}) begin
      n_err++; $display("FAIL single_hold: got data_ok=%b rdata=%h need 0 02800000",
                        inst_sram_data_ok, inst_sram_rdata);
    end
  endtask

  task automatic test_ar_stall();
    int hs;
    hs = 0;
    drive(1'b1, 32'h1C00_0040, 1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1C00_0080, (i == 5), 1'b0, '0, '0);
      @(negedge clk);
      if (arvalid && arready) hs++;
      n_cmp++;
      if ({arvalid, araddr, inst_sram_addr_ok} !== {1'b1, 32'h1C00_0040, 1'b0}) begin
        n_err++; $display("FAIL stall_hold[%0d]: got arvalid=%b araddr=%h addr_ok=%b need 1 1c000040 0",
                          i, arvalid, araddr, inst_sram_addr_ok);
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b1, 32'hCAFE_0001, 4'h0);
    @(negedge clk);
    if (arvalid && arready) hs++;
    n_cmp++;
    if (hs !== 1) begin
      n_err++; $display("FAIL stall_hs_count: got %0d AR handshakes need 1", hs);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_err++; $display("FAIL stall_data: got data_ok=%b rdata=%h need 1 cafe0001",
                        inst_sram_data_ok, inst_sram_rdata);
    end
    tick();
  endtask

  task automatic test_two_outstanding();
    drive(1'b1, 32'h1C00_0000, 1'b1, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);            tick();
    drive(1'b1, 32'h1C00_0004, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if (inst_sram_addr_ok !== 1'b1) begin
      n_err++; $display("FAIL two_second_accept: got addr_ok=%b need 1", inst_sram_addr_ok);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1C00_0008, 1'b1, 1'b0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if ({inst_sram_addr_ok, rready, inst_sram_data_ok} !== 3'b010) begin
        n_err++; $display("FAIL two_full[%0d]: got addr_ok/rready/data_ok=%b need 010",
                          i, {inst_sram_addr_ok, rready, inst_sram_data_ok});
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 32'hD000_0000, 4'h0); tick();
    drive(1'b0, '0, 1'b0, 1'b1, 32'hD000_0004, 4'h0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata, inst_sram_addr_ok} !== {1'b1, 32'hD000_0000, 1'b1}) begin
      n_err++; $display("FAIL two_first: got data_ok=%b rdata=%h addr_ok=%b need 1 d0000000 1",
                        inst_sram_data_ok, inst_sram_rdata, inst_sram_addr_ok);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata, rready} !== {1'b1, 32'hD000_0004, 1'b0}) begin
      n_err++; $display("FAIL two_second: got data_ok=%b rdata=%h rready=%b need 1 d0000004 0",
                        inst_sram_data_ok, inst_sram_rdata, rready);
    end
    tick();
  endtask

  task automatic test_accept_with_r();
    drive(1'b1, 32'h1C00_0100, 1'b1, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);            tick();
    drive(1'b1, 32'h1C00_0104, 1'b1, 1'b1, 32'hBEEF_0100, 4'h0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_addr_ok, rready} !== 2'b11) begin
      n_err++; $display("FAIL overlap_same: got addr_ok/rready=%b need 11", {inst_sram_addr_ok, rready});
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata, arvalid, araddr, rready, inst_sram_addr_ok}
        !== {1'b1, 32'hBEEF_0100, 1'b1, 32'h1C00_0104, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL overlap_next: got data_ok=%b rdata=%h arvalid=%b araddr=%h rready=%b addr_ok=%b need 1 beef0100 1 1c000104 1 0",
                        inst_sram_data_ok, inst_sram_rdata, arvalid, araddr, rready, inst_sram_addr_ok);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 32'hBEEF_0104, 4'h0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata, rready} !== {1'b1, 32'hBEEF_0104, 1'b0}) begin
      n_err++; $display("FAIL overlap_drain: got data_ok=%b rdata=%h rready=%b need 1 beef0104 0",
                        inst_sram_data_ok, inst_sram_rdata, rready);
    end
    tick();
  endtask

  task automatic test_stray_r();
    drive(1'b0, '0, 1'b0, 1'b1, 32'h0BAD_0BAD, 4'h3);
    @(negedge clk);
    n_cmp++;
    if (rready !== 1'b0) begin
      n_err++; $display("FAIL stray_rready: got %b need 0", rready);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b0, 32'hBEEF_0104}) begin
      n_err++; $display("FAIL stray_data_ok: got data_ok=%b rdata=%h need 0 beef0104",
                        inst_sram_data_ok, inst_sram_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h1C00_0200, 1'b1, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);            tick();
    drive(1'b1, 32'h1C00_0204, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({arvalid, rready, inst_sram_addr_ok} !== 3'b110) begin
      n_err++; $display("FAIL midrst_pre: got arvalid/rready/addr_ok=%b need 110",
                        {arvalid, rready, inst_sram_addr_ok});
    end
    resetn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 32'h7777_7777, 4'h0);
    tick();
    resetn = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok} !== 4'b0001) begin
      n_err++; $display("FAIL midrst_post: got arvalid/rready/data_ok/addr_ok=%b need 0001",
                        {arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok});
    end
    tick();
  endtask

  // One random cycle: tb acts as IF master and in-order AXI slave.
  task automatic rand_cycle(input bit allow_req);
    logic [31:0] a, e;
    bit          rv;
    logic [31:0] d;
    logic [3:0]  id;
    a  = $urandom() & 32'hFFFF_FFFC;
    rv = 1'b0; d = $urandom(); id = 4'($urandom());
    if (ar_q.size() > 0 && ($urandom_range(0, 2) != 0)) begin
      rv = 1'b1; d = mem_word(ar_q[0]); id = ar_q[0][5:2];
    end else if (m_cnt == 0 && $urandom_range(0, 7) == 0) begin
      rv = 1'b1;
    end
    inst_sram_size = 2'($urandom_range(0, 2));
    drive(allow_req && ($urandom_range(0, 1) == 1), a, ($urandom_range(0, 2) != 0), rv, d, id);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok}
        !== {exp_addr_ok(), m_ar_pend, (m_cnt != 0), m_dok}) begin
      n_err++; $display("FAIL rand_ctrl: got addr_ok/arvalid/rready/data_ok=%b need %b",
                        {inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok},
                        {exp_addr_ok(), m_ar_pend, (m_cnt != 0), m_dok});
    end
    if (m_ar_pend) begin
      n_cmp++;
      if ({araddr, arsize} !== {m_araddr, 1'b0, m_arsize}) begin
        n_err++; $display("FAIL rand_ar: got araddr=%h arsize=%b need %h %b",
                          araddr, arsize, m_araddr, {1'b0, m_arsize});
      end
    end
    if (m_dok) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL rand_extra_data: got data_ok with rdata=%h need no pulse", inst_sram_rdata);
      end else begin
        e = sb_q.pop_front();
        if ({inst_sram_rdata, axi_rid_out} !== {mem_word(e), e[5:2]}) begin
          n_err++; $display("FAIL rand_data: got rdata=%h rid=%h need %h %h",
                            inst_sram_rdata, axi_rid_out, mem_word(e), e[5:2]);
        end
      end
    end
    if (inst_sram_req && exp_addr_ok()) sb_q.push_back(inst_sram_addr);
    if (m_ar_pend && arready) ar_q.push_back(m_araddr);
    if (rvalid && m_cnt != 0) void'(ar_q.pop_front());
    tick();
  endtask

  task automatic test_random();
    int guard;
    ar_q.delete();
    sb_q.delete();
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);
    guard = 0;
    while ((sb_q.size() != 0 || m_dok || m_cnt != 0) && guard < 100) begin
      rand_cycle(1'b0);
      guard++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL rand_drain: got %0d fetches unanswered need 0", sb_q.size());
    end
  endtask

  initial begin
    inst_sram_wr = 1'b0;
    rresp        = 2'b00;
    rlast        = 1'b1;
    test_reset();
    test_single();
    test_ar_stall();
    test_two_outstanding();
    test_accept_with_r();
    test_stray_r();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
Responder end of the instruction-fetch SRAM-like interface (req / addr_ok / data_ok). Accepts fetch requests from the IF stage and converts each into a single-beat AXI read on the AR channel. Returns each R beat to IF as a one-cycle data_ok pulse with rdata and the returned ID. Sits between the IF stage and the AXI crossbar/arbiter.

Parameters:
ARID, 4'h0, constant AXI ID driven on arid for every fetch.
MAX_OUTSTANDING, 2, maximum number of accepted requests not yet answered (1..3; 2-bit counter).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_sram_req  in  1  IF request valid
inst_sram_wr  in  1  write flag; ignored, every request is a read
inst_sram_size  in  2  log2 bytes (0=1B, 1=2B, 2=4B)
inst_sram_addr  in  32  physical fetch address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  one-cycle pulse: rdata valid
inst_sram_rdata  out  32  returned instruction word
axi_rid_out  out  4  rid of the beat being returned with data_ok (feeds IF axi_arid)
arid  out  4  = ARID
araddr  out  32  latched address
arlen  out  8  = 0
arsize  out  3  = {1'b0, latched size}
arburst  out  2  = 2'b01
arlock  out  2  = 0
arcache  out  4  = 0
arprot  out  3  = 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R ID
rdata  in  32  R data
rresp  in  2  ignored
rlast  in  1  ignored (single beat)
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- AR FSM, two states: AR_IDLE, AR_SEND. Reset -> AR_IDLE.
- addr_ok = (state==AR_IDLE) & (out_cnt < MAX_OUTSTANDING); combinational, may be high without req. Accept = req & addr_ok.
- On accept: latch addr, size; next state AR_SEND; arvalid=1 from the next cycle.
- AR_SEND: arvalid held high, araddr/arsize stable until arvalid & arready; then AR_IDLE. AR_IDLE -> AR_IDLE with no accept. No new request is accepted while in AR_SEND. Minimum accept-to-accept spacing is 2 cycles.
- out_cnt (2 bits): +1 on accept, -1 on R handshake (rvalid & rready), unchanged if both occur in the same cycle. Never exceeds MAX_OUTSTANDING and never underflows.
- rready = (out_cnt != 0). An rvalid while out_cnt==0 is not accepted.
- On R handshake: register rdata -> inst_sram_rdata and rid -> axi_rid_out. inst_sram_data_ok = 1 in the following cycle only.
- Back-to-back R beats give consecutive data_ok pulses. There is no backpressure from IF.
- Latency for arready=1 and R returned 1 cycle after the AR handshake:
  - cycle 0 accept
  - cycle 1 AR handshake
  - cycle 2 R handshake
  - cycle 3 data_ok
- Responses are returned in AXI arrival order. A single ID guarantees in-order delivery.
- rresp is not checked. Bus errors are outside this block's scope.
- inst_sram_rdata and axi_rid_out hold their last values between pulses.
- Reset values: arvalid=0, rready=0, inst_sram_data_ok=0, inst_sram_rdata=0, axi_rid_out=0, araddr=0, arsize=0, out_cnt=0. addr_ok is low during reset.
- Reset mid-transaction clears FSM, counter and pulse immediately. The AXI slave is reset by the same resetn, so no orphan beats are expected.
- Size mapping: size=2 -> arsize=3'b010; size=0 -> 3'b000.

Test Plan:
- Single fetch, addr 0x1C000000, arready=1, slave returns 0x02800000 one cycle after AR. Required:
  - addr_ok in cycle 0; arvalid cycle 1 with araddr 0x1C000000, arsize 2.
  - data_ok pulse in cycle 3, rdata 0x02800000, axi_rid_out 0.
- arready held low for 5 cycles. Required:
  - arvalid and araddr stable throughout; addr_ok=0 during AR_SEND.
  - Single AR handshake in the cycle arready rises.
- Two requests (0x1C000000, 0x1C000004) accepted, with R delayed 10 cycles. Required:
  - out_cnt=2; addr_ok=0 on a third req until the first R handshake.
  - Data returned in order, with two data_ok pulses.
- Accept in the same cycle as an R handshake while out_cnt=1. Required: out_cnt stays 1; data_ok pulses next cycle; new arvalid next cycle.
- Stray rvalid with out_cnt=0. Required: rready=0, no data_ok.
- resetn low for 1 cycle while in AR_SEND with out_cnt=2. Required: next cycle arvalid=0, rready=0, data_ok=0, addr_ok=1.
